// File: rtl/hex_count_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hex_count_pkg
// Description : Shared constants and helpers for the hex/BCD tick counter.
//               Provides the radix constants, the digit width and the
//               prescaler width function.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_count_pkg;

  localparam int RADIX_HEX = 16;
  localparam int RADIX_BCD = 10;
  localparam int DIGIT_W   = 4;

  // Prescaler register width: clog2 of the divide ratio, never below one bit
  // so that a divide-by-1 configuration still has a legal register.
  function automatic int prescale_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_tick_counter_if.sv
`default_nettype none
// ============================================================================
// Interface   : hex_tick_counter_if
// Description : Control/status bundle for hex_tick_counter.
//   master : drives Run, Up, Load, LoadVal, Clear; observes Digits, Tick, Wrap
//   slave  : the counter itself (the reverse directions)
//   Run     - level, prescaler advances / counter steps on terminal count
//   Up      - level, 1 = count up, 0 = count down
//   Load    - synchronous load strobe, LoadVal digit 0 in [3:0]
//   Clear   - synchronous clear strobe
//   Digits  - registered count, digit 0 in [3:0]
//   Tick    - one-cycle pulse per count step
//   Wrap    - one-cycle pulse when a step wraps the full count
// Revision    : 1.0 - initial release
// ============================================================================
interface hex_tick_counter_if
  import hex_count_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic                        Run;
  logic                        Up;
  logic                        Load;
  logic [DIGIT_W*DIGITS-1:0]   LoadVal;
  logic                        Clear;
  logic [DIGIT_W*DIGITS-1:0]   Digits;
  logic                        Tick;
  logic                        Wrap;

  modport master (
    output Run, Up, Load, LoadVal, Clear,
    input  Digits, Tick, Wrap
  );

  modport slave (
    input  Run, Up, Load, LoadVal, Clear,
    output Digits, Tick, Wrap
  );

endinterface
`default_nettype wire

// File: rtl/hex_digit_cell.sv
`default_nettype none
// ============================================================================
// Module      : hex_digit_cell
// Description : One counter digit register with ripple carry/borrow.
//   clk, rst    - clock, asynchronous active-high reset
//   i_step      - step enable (already qualified by clear/load priority)
//   i_up        - direction, 1 = increment, 0 = decrement
//   i_cin       - carry (up) / borrow (down) from the lower digit
//   i_load      - load enable, i_load_val saturated to RADIX-1
//   i_clear     - clear enable, highest synchronous priority
//   o_digit     - registered digit value
//   o_cout      - carry/borrow to the next digit (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module hex_digit_cell
  import hex_count_pkg::*;
#(
  parameter int RADIX = RADIX_HEX
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_step,
  input  wire logic               i_up,
  input  wire logic               i_cin,
  input  wire logic               i_load,
  input  wire logic [DIGIT_W-1:0] i_load_val,
  input  wire logic               i_clear,
  output logic      [DIGIT_W-1:0] o_digit,
  output logic                    o_cout
);

  localparam logic [DIGIT_W-1:0] c_max = DIGIT_W'(RADIX - 1);

  logic [DIGIT_W-1:0] r_digit;
  logic               w_at_limit;
  logic [DIGIT_W-1:0] w_step_val;
  logic [DIGIT_W-1:0] w_load_sat;

  // Limit is the value that rolls over in the current direction.
  assign w_at_limit = i_up ? (r_digit == c_max) : (r_digit == '0);
  assign o_cout     = i_cin & w_at_limit;

  always_comb begin
    w_step_val = r_digit;
    if (i_up) begin
      w_step_val = w_at_limit ? '0 : r_digit + 1'b1;
    end else begin
      w_step_val = w_at_limit ? c_max : r_digit - 1'b1;
    end
  end

  // For hex c_max is 15, so the clamp is a no-op there.
  assign w_load_sat = (i_load_val > c_max) ? c_max : i_load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= '0;
    end else if (i_clear) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= w_load_sat;
    end else if (i_step && i_cin) begin
      r_digit <= w_step_val;
    end
  end

  assign o_digit = r_digit;

endmodule
`default_nettype wire

// File: rtl/hex_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : hex_tick_counter
// Description : Multi-digit hex/BCD up/down counter with clock prescaler.
//   Clock   - system clock, rising edge
//   Reset   - asynchronous active-high reset
//   bus     - hex_tick_counter_if.slave (Run, Up, Load, LoadVal, Clear in;
//             Digits, Tick, Wrap out)
// Revision    : 1.0 - initial release
// ============================================================================
module hex_tick_counter
  import hex_count_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int RADIX    = RADIX_HEX,
  parameter int TICK_DIV = 50_000_000
) (
  input  wire logic          Clock,
  input  wire logic          Reset,
  hex_tick_counter_if.slave  bus
);

  localparam int              c_pw   = prescale_width(TICK_DIV);
  localparam logic [c_pw-1:0] c_term = c_pw'(TICK_DIV - 1);

  logic [c_pw-1:0]           r_pcnt;
  logic                      r_tick;
  logic                      r_wrap;
  logic                      w_term;
  logic                      w_step;
  logic [DIGITS:0]           w_carry;
  logic [DIGIT_W*DIGITS-1:0] w_digits;

  assign w_term = (r_pcnt == c_term);
  // A step that coincides with Clear or Load is dropped entirely.
  assign w_step = bus.Run & w_term & ~bus.Clear & ~bus.Load;

  // Digit 0 always sees an incoming carry; higher digits ripple.
  assign w_carry[0] = 1'b1;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      hex_digit_cell #(
        .RADIX (RADIX)
      ) u_cell (
        .clk        (Clock),
        .rst        (Reset),
        .i_step     (w_step),
        .i_up       (bus.Up),
        .i_cin      (w_carry[i]),
        .i_load     (bus.Load),
        .i_load_val (bus.LoadVal[DIGIT_W*i +: DIGIT_W]),
        .i_clear    (bus.Clear),
        .o_digit    (w_digits[DIGIT_W*i +: DIGIT_W]),
        .o_cout     (w_carry[i+1])
      );
    end
  endgenerate

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= w_step;
      // Carry out of the top digit means every digit rolled over.
      r_wrap <= w_step & w_carry[DIGITS];
      if (bus.Clear || bus.Load) begin
        r_pcnt <= '0;
      end else if (bus.Run) begin
        r_pcnt <= w_term ? '0 : r_pcnt + 1'b1;
      end
    end
  end

  assign bus.Digits = w_digits;
  assign bus.Tick   = r_tick;
  assign bus.Wrap   = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_hex_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_tick_counter
// Description : Directed self-checking bench for hex_tick_counter.
//   u_a : DIGITS=2, RADIX=16, TICK_DIV=4
//   u_b : DIGITS=2, RADIX=10, TICK_DIV=4
//   u_c : DIGITS=1, RADIX=16, TICK_DIV=1
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_tick_counter;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  logic rst_c;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hex_tick_counter_if #(.DIGITS(2)) if_a ();
  hex_tick_counter_if #(.DIGITS(2)) if_b ();
  hex_tick_counter_if #(.DIGITS(1)) if_c ();

  hex_tick_counter #(.DIGITS(2), .RADIX(16), .TICK_DIV(4)) u_a (
    .Clock (clk), .Reset (rst_a), .bus (if_a.slave)
  );
  hex_tick_counter #(.DIGITS(2), .RADIX(10), .TICK_DIV(4)) u_b (
    .Clock (clk), .Reset (rst_b), .bus (if_b.slave)
  );
  hex_tick_counter #(.DIGITS(1), .RADIX(16), .TICK_DIV(1)) u_c (
    .Clock (clk), .Reset (rst_c), .bus (if_c.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    if_a.Run = 0; if_a.Up = 1; if_a.Load = 0; if_a.Clear = 0; if_a.LoadVal = '0;
    if_b.Run = 0; if_b.Up = 1; if_b.Load = 0; if_b.Clear = 0; if_b.LoadVal = '0;
    if_c.Run = 0; if_c.Up = 1; if_c.Load = 0; if_c.Clear = 0; if_c.LoadVal = '0;

    // Reset asserted before any clock edge: must act asynchronously.
    #2;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    chk("rst_digits", if_a.Digits, 32'h00);
    chk("rst_tick",   if_a.Tick,   32'h0);
    chk("rst_wrap",   if_a.Wrap,   32'h0);

    edges(1);
    rst_b = 1'b0;
    rst_c = 1'b0;

    // ---- TICK_DIV=1: step every edge, Wrap every 16 ----
    if_c.Run = 1;
    for (int k = 1; k <= 32; k++) begin
      edges(1);
      chk("c_digits", if_c.Digits, 32'(k % 16));
      chk("c_tick",   if_c.Tick,   32'h1);
      chk("c_wrap",   if_c.Wrap,   32'((k % 16) == 0));
    end
    if_c.Run = 0;

    // ---- Hex up count from reset release ----
    rst_a = 1'b0;
    if_a.Run = 1;
    if_a.Up  = 1;
    edges(3);
    chk("a_pre_step_digits", if_a.Digits, 32'h00);
    chk("a_pre_step_tick",   if_a.Tick,   32'h0);
    edges(1);                                    // edge 4
    chk("a_step1_digits", if_a.Digits, 32'h01);
    chk("a_step1_tick",   if_a.Tick,   32'h1);
    edges(1);                                    // edge 5
    chk("a_tick_one_cycle", if_a.Tick, 32'h0);
    edges(58);                                   // edge 63
    chk("a_0f", if_a.Digits, 32'h0F);
    edges(1);                                    // edge 64
    chk("a_10", if_a.Digits, 32'h10);
    chk("a_10_tick", if_a.Tick, 32'h1);
    edges(959);                                  // edge 1023
    chk("a_ff", if_a.Digits, 32'hFF);
    chk("a_ff_wrap", if_a.Wrap, 32'h0);
    edges(1);                                    // edge 1024
    chk("a_wrap_digits", if_a.Digits, 32'h00);
    chk("a_wrap",        if_a.Wrap,   32'h1);
    chk("a_wrap_tick",   if_a.Tick,   32'h1);
    edges(1);
    chk("a_wrap_end", if_a.Wrap, 32'h0);
    chk("a_tick_end", if_a.Tick, 32'h0);

    // ---- Load, then Clear+Load together ----
    if_a.Load = 1; if_a.LoadVal = 8'h25;
    edges(1);
    chk("a_load25", if_a.Digits, 32'h25);
    chk("a_load_tick", if_a.Tick, 32'h0);
    if_a.Clear = 1; if_a.LoadVal = 8'h77;
    edges(1);
    chk("a_clear_over_load", if_a.Digits, 32'h00);
    if_a.Clear = 0; if_a.Load = 0;

    // ---- Run pause at pcnt=2 ----
    edges(2);
    if_a.Run = 0;
    edges(10);
    chk("a_hold_digits", if_a.Digits, 32'h00);
    chk("a_hold_tick",   if_a.Tick,   32'h0);
    if_a.Run = 1;
    edges(1);
    chk("a_resume1_digits", if_a.Digits, 32'h00);
    edges(1);
    chk("a_resume2_digits", if_a.Digits, 32'h01);
    chk("a_resume2_tick",   if_a.Tick,   32'h1);

    // ---- Async reset mid-prescale at 0x47 ----
    if_a.Load = 1; if_a.LoadVal = 8'h47;
    edges(1);
    chk("a_load47", if_a.Digits, 32'h47);
    if_a.Load = 0;
    edges(2);
    #2;
    rst_a = 1'b1;
    #1;
    chk("a_async_digits", if_a.Digits, 32'h00);
    chk("a_async_tick",   if_a.Tick,   32'h0);
    chk("a_async_wrap",   if_a.Wrap,   32'h0);
    #1;
    rst_a = 1'b0;
    edges(3);
    chk("a_post_rst_pre", if_a.Digits, 32'h00);
    edges(1);
    chk("a_post_rst_step", if_a.Digits, 32'h01);
    chk("a_post_rst_tick", if_a.Tick,   32'h1);
    if_a.Run = 0;

    // ---- BCD: load saturation, carry, load-on-step, wrap both ways ----
    if_b.Run = 1; if_b.Up = 1; if_b.Load = 1; if_b.LoadVal = 8'h3A;
    edges(1);
    chk("b_load3a", if_b.Digits, 32'h39);
    chk("b_load_tick", if_b.Tick, 32'h0);
    if_b.Load = 0;
    edges(3);
    chk("b_hold39", if_b.Digits, 32'h39);
    edges(1);
    chk("b_39_to_40", if_b.Digits, 32'h40);
    chk("b_40_tick",  if_b.Tick,   32'h1);
    edges(3);                                    // pcnt now at terminal
    if_b.Load = 1; if_b.LoadVal = 8'h09;
    edges(1);
    chk("b_load_on_step", if_b.Digits, 32'h09);
    chk("b_load_on_step_tick", if_b.Tick, 32'h0);
    chk("b_load_on_step_wrap", if_b.Wrap, 32'h0);
    if_b.Load = 0;
    edges(4);
    chk("b_09_to_10", if_b.Digits, 32'h10);
    chk("b_10_tick",  if_b.Tick,   32'h1);
    if_b.Load = 1; if_b.LoadVal = 8'hAF;
    edges(1);
    chk("b_load_sat", if_b.Digits, 32'h99);
    if_b.Load = 0;
    edges(4);
    chk("b_up_wrap_digits", if_b.Digits, 32'h00);
    chk("b_up_wrap",        if_b.Wrap,   32'h1);
    chk("b_up_wrap_tick",   if_b.Tick,   32'h1);
    if_b.Up = 0;
    edges(1);
    chk("b_wrap_end", if_b.Wrap, 32'h0);
    edges(3);
    chk("b_down_wrap_digits", if_b.Digits, 32'h99);
    chk("b_down_wrap",        if_b.Wrap,   32'h1);
    edges(4);
    chk("b_down_98",      if_b.Digits, 32'h98);
    chk("b_down_98_wrap", if_b.Wrap,   32'h0);
    chk("b_down_98_tick", if_b.Tick,   32'h1);
    if_b.Run = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
